// File: rtl/elm_weight_read_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// elm_weight_read_sequencer_pkg
// Shared definitions for the per-neuron weight read sequencer:
//   - state_e        : sequencer FSM encoding (IDLE / RUN / DRAIN)
//   - DATA_W_DEF     : default feature / weight width
//   - ADDR_W_DEF     : default weight memory address width
//   - MNIST_FEATURES : input features per sample, i.e. weights per neuron
// -----------------------------------------------------------------------------
package elm_weight_read_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 10;
  localparam int MNIST_FEATURES = 784;

endpackage

// File: rtl/elm_weight_read_sequencer_if.sv
// -----------------------------------------------------------------------------
// elm_weight_read_sequencer_if
// Bundles the three buses the sequencer sits between:
//   feature stream : x_data, x_valid (in), x_ready (out)
//   weight memory  : ren, raddr (out), wout (in, valid the cycle after ren)
//   operand stream : op_x, op_w, op_valid, op_last (out), op_ready (in)
// Modports: master = sequencer side, slave = environment side.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid && ready are both high. A producer holding valid keeps its data
// and flags stable until that transfer; ready may depend combinationally on
// the receiver's own state but never on the same-cycle valid of that stream.
// -----------------------------------------------------------------------------
interface elm_weight_read_sequencer_if
  import elm_weight_read_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] x_data;
  logic              x_valid;
  logic              x_ready;

  logic              ren;
  logic [ADDR_W:0]   raddr;
  logic [DATA_W-1:0] wout;

  logic [DATA_W-1:0] op_x;
  logic [DATA_W-1:0] op_w;
  logic              op_valid;
  logic              op_last;
  logic              op_ready;

  modport master (
    input  x_data, x_valid, wout, op_ready,
    output x_ready, ren, raddr, op_x, op_w, op_valid, op_last
  );

  modport slave (
    output x_data, x_valid, wout, op_ready,
    input  x_ready, ren, raddr, op_x, op_w, op_valid, op_last
  );

endinterface

// File: rtl/elm_weight_read_sequencer.sv
// -----------------------------------------------------------------------------
// elm_weight_read_sequencer
// Drives the single read port of one neuron's weight BRAM in lock-step with
// the incoming feature stream and emits aligned (x, w) operand pairs.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   start      begin one neuron pass (sampled only in IDLE)
//   clr        synchronous abort to IDLE, no done pulse
//   bus        feature / memory / operand buses (master modport)
//   busy       high while in RUN or DRAIN
//   done       one-cycle pulse after the last pair is accepted
//   dbg_state  current FSM state
//
// Each accepted feature issues one BRAM read; the feature is registered while
// the memory registers the weight, so both appear together one cycle later.
// op_w is wout passed straight through: while a pair is stalled no read is
// issued, so the memory output (and hence op_w) holds on its own.
// -----------------------------------------------------------------------------
module elm_weight_read_sequencer
  import elm_weight_read_sequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_WEIGHTS = MNIST_FEATURES
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         clr,
  elm_weight_read_sequencer_if.master  bus,
  output logic                         busy,
  output logic                         done,
  output state_e                       dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] op_x_q;
  logic              op_valid_q;
  logic              op_last_q;
  logic              done_q;

  logic advance;
  logic fire;
  logic is_last;

  // The output slot can take a new pair when it is empty or being emptied.
  assign advance = !op_valid_q || bus.op_ready;
  assign bus.x_ready = (state_q == ST_RUN) && advance;
  assign fire    = bus.x_valid && bus.x_ready;
  assign is_last = (cnt_q == LAST_IDX);

  assign bus.ren      = fire;
  assign bus.raddr    = {1'b0, cnt_q};
  assign bus.op_x     = op_x_q;
  assign bus.op_w     = bus.wout;
  assign bus.op_valid = op_valid_q;
  assign bus.op_last  = op_last_q;

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_x_q     <= '0;
      op_valid_q <= 1'b0;
      op_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else if (clr) begin
      // Abort drops the in-flight pair; op_x keeps stale data but is
      // qualified by op_valid.
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
      op_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Output slot: a fire refills it, an accept without a fire empties it.
      if (fire) begin
        op_x_q     <= bus.x_data;
        op_valid_q <= 1'b1;
        op_last_q  <= is_last;
        // Counter parks on the last index; start rewinds it.
        if (!is_last) begin
          cnt_q <= cnt_q + ADDR_W'(1);
        end
      end else if (op_valid_q && bus.op_ready) begin
        op_valid_q <= 1'b0;
        op_last_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (fire && is_last) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (op_valid_q && bus.op_ready && op_last_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elm_weight_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_elm_weight_read_sequencer
// Two instances: a full 784-weight sequencer exercised by hand-written pass
// sequences with an expected queue, and a 1-weight sequencer driven from a
// per-cycle vector table. Each instance has a 1-cycle BRAM model returning
// mem[a] = a + 16'h0100.
// -----------------------------------------------------------------------------
module tb_elm_weight_read_sequencer;
  import elm_weight_read_sequencer_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int NW = 784;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0 : NUM_WEIGHTS = 784 ----------------
  logic   start = 1'b0, clr = 1'b0, busy, done;
  state_e dbg_state;
  elm_weight_read_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  elm_weight_read_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NUM_WEIGHTS(NW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .clr       (clr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always @(posedge clk) if (bus.ren) bus.wout <= DW'(bus.raddr) + 16'h0100;

  // ---------------- DUT 1 : NUM_WEIGHTS = 1 ----------------
  logic   start1 = 1'b0, clr1 = 1'b0, busy1, done1;
  state_e dbg_state1;
  elm_weight_read_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  elm_weight_read_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NUM_WEIGHTS(1)) dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start1),
    .clr       (clr1),
    .bus       (bus1),
    .busy      (busy1),
    .done      (done1),
    .dbg_state (dbg_state1)
  );

  always @(posedge clk) if (bus1.ren) bus1.wout <= DW'(bus1.raddr) + 16'h0100;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.x_valid = 1'b0; bus.x_data = '0; bus.op_ready = 1'b0;
    bus1.x_valid = 1'b0; bus1.x_data = '0; bus1.op_ready = 1'b0;
    start = 1'b0; clr = 1'b0; start1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {bus.x_ready, bus.ren, bus.op_valid, bus.op_last, busy, done}, 0);
    check("rst_raddr_opx", {5'd0, bus.raddr, bus.op_x}, 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_outs1", {bus1.x_ready, bus1.ren, bus1.op_valid, bus1.op_last, busy1, done1}, 0);
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  // One pass on DUT 0. stall_at: pair index held with op_ready=0 for 5
  // cycles (-1 none); clr_at: abort once this many pairs are accepted
  // (-1 none); rst_drain: pulse reset while the last pair sits in DRAIN.
  task automatic run_pass(input bit bubble, input int stall_at, input int clr_at,
                          input bit rst_drain, input bit chk_lat);
    int fires, acc, stall_cycles, c0, t;
    bit done_seen, stalled_prev;
    logic [DW-1:0] hold_x, hold_w, e;
    exp_q.delete();
    fires = 0; acc = 0; stall_cycles = 0; done_seen = 0; stalled_prev = 0;
    hold_x = '0; hold_w = '0;
    @(posedge clk); #1 start = 1'b1; c0 = cyc; bus.x_valid = 1'b0; bus.op_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (t = 0; t < 4000; t++) begin
      if (clr_at >= 0 && acc == clr_at) begin
        bus.op_ready = 1'b0; bus.x_valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        check("clr_pre_valid", bus.op_valid, 1);
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("clr_outs", {bus.op_valid, bus.op_last, busy, done, bus.x_ready}, 0);
        check("clr_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) begin
          @(negedge clk);
          check("clr_no_done", done, 0);
        end
        return;
      end
      if (rst_drain && fires == NW) begin
        bus.op_ready = 1'b0; bus.x_valid = 1'b0;
        @(negedge clk);
        check("drain_hold", {busy, bus.op_valid, bus.op_last}, 3'b111);
        check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        #1 rstn = 1'b0;
        #1;
        check("rst_async_outs",
              {bus.x_ready, bus.ren, bus.raddr, bus.op_valid, bus.op_last, busy, done}, 0);
        check("rst_async_opx", bus.op_x, 0);
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_start_ignored", busy, 0);
        rstn = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_after_state", 32'(dbg_state), 32'(ST_IDLE));
        return;
      end
      bus.x_valid  = !bubble || (t % 2 == 0);
      bus.x_data   = DW'(fires);
      bus.op_ready = !(acc == stall_at && stall_cycles < 5);
      @(negedge clk);
      if (bus.ren) begin
        check("raddr", 32'(bus.raddr), fires);
        exp_q.push_back(DW'(fires));
        fires++;
      end
      if (!bus.x_valid) check("ren_bubble", bus.ren, 0);
      if (bus.op_valid) check("op_last", bus.op_last, 32'(acc == NW - 1));
      if (bus.op_valid && !bus.op_ready) begin
        if (stalled_prev) check("stall_hold", {bus.op_x, bus.op_w}, {hold_x, hold_w});
        check("stall_quiet", {bus.x_ready, bus.ren}, 0);
        hold_x = bus.op_x; hold_w = bus.op_w; stalled_prev = 1'b1; stall_cycles++;
      end else begin
        stalled_prev = 1'b0;
      end
      if (bus.op_valid && bus.op_ready) begin
        if (exp_q.size() == 0) begin
          check("pair_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("op_x", bus.op_x, e);
          check("op_w", bus.op_w, e + 16'h0100);
        end
        acc++;
      end
      if (done) begin
        check("pairs", acc, NW);
        if (chk_lat) check("latency", cyc - c0, NW + 2);
        done_seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.x_valid = 1'b0;
    if (!done_seen) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      check("done_pulse_busy", {done, busy}, 0);
      if (stall_at >= 0) check("stall_len", stall_cycles, 5);
    end
  endtask

  // ---------------- vector table for the NUM_WEIGHTS=1 instance ----------------
  typedef struct {
    logic          start;
    logic          clr;
    logic          x_valid;
    logic          op_ready;
    logic [DW-1:0] x_data;
    logic [5:0]    exp_flags;  // {x_ready, ren, op_valid, op_last, busy, done}
    logic [DW-1:0] exp_x;
    logic [DW-1:0] exp_w;
  } vec_t;

  vec_t tbl[16];

  task automatic run_table();
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0055, 6'b110010, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0099, 6'b001110, 16'h0055, 16'h0100};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 6'b000001, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0066, 6'b110010, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b001110, 16'h0066, 16'h0100};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b001110, 16'h0066, 16'h0100};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6'b001110, 16'h0066, 16'h0100};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000001, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0077, 6'b110010, 16'h0000, 16'h0000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 6'b001110, 16'h0077, 16'h0100};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      start1 = tbl[i].start; clr1 = tbl[i].clr;
      bus1.x_valid = tbl[i].x_valid; bus1.op_ready = tbl[i].op_ready;
      bus1.x_data = tbl[i].x_data;
      @(negedge clk);
      check($sformatf("nw1_flags[%0d]", i),
            {bus1.x_ready, bus1.ren, bus1.op_valid, bus1.op_last, busy1, done1},
            tbl[i].exp_flags);
      if (tbl[i].exp_flags[4]) check($sformatf("nw1_raddr[%0d]", i), bus1.raddr, 0);
      if (tbl[i].exp_flags[3])
        check($sformatf("nw1_pair[%0d]", i), {bus1.op_x, bus1.op_w},
              {tbl[i].exp_x, tbl[i].exp_w});
    end
    @(posedge clk); #1;
    start1 = 1'b0; clr1 = 1'b0; bus1.x_valid = 1'b0; bus1.op_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    run_table();
    run_pass(1'b0, -1, -1, 1'b0, 1'b1);   // full pass, latency
    run_pass(1'b0, 10, -1, 1'b0, 1'b0);   // downstream stall at pair 10
    run_pass(1'b1, -1, -1, 1'b0, 1'b0);   // input bubbles
    run_pass(1'b0, -1, 300, 1'b0, 1'b0);  // clr at pair 300
    run_pass(1'b0, -1, -1, 1'b0, 1'b1);   // restart after clr from raddr 0
    run_pass(1'b0, -1, -1, 1'b1, 1'b0);   // async reset in DRAIN
    run_pass(1'b0, -1, -1, 1'b0, 1'b1);   // clean pass after reset
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
